// File: rtl/debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : debug_ctrl
// Description : UART-driven debug controller. Decodes host command bytes to
//               load instruction memory, run or single-step the datapath, and
//               dump PC plus register file back over the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_ctrl #(
    parameter int IMEM_AW = 8,
    parameter int NREGS   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_done,
    output logic               cpu_en,
    output logic               cpu_rst,
    input  logic               halt,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic [5:0]         dbg_sel,
    input  logic [31:0]        dbg_data,
    output logic               busy
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_LD_CNT     = 4'd1;
    localparam logic [3:0] S_LD_DATA    = 4'd2;
    localparam logic [3:0] S_LD_ACK     = 4'd3;
    localparam logic [3:0] S_RUN        = 4'd4;
    localparam logic [3:0] S_STEP       = 4'd5;
    localparam logic [3:0] S_DUMP_SEL   = 4'd6;
    localparam logic [3:0] S_DUMP_LATCH = 4'd7;
    localparam logic [3:0] S_DUMP_TX    = 4'd8;
    localparam logic [3:0] S_DUMP_WAIT  = 4'd9;

    localparam logic [7:0] c_CMD_LOAD = 8'h4C;
    localparam logic [7:0] c_CMD_RUN  = 8'h52;
    localparam logic [7:0] c_CMD_STEP = 8'h53;
    localparam logic [7:0] c_CMD_DUMP = 8'h44;
    localparam logic [7:0] c_ACK_BYTE = 8'h4B;
    localparam logic [5:0] c_PC_SEL   = 6'd32;
    // Word index 0 is the PC; index k (1..NREGS) is register k-1.
    localparam logic [5:0] c_LAST_IDX = 6'(NREGS);

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic [8:0]         r_cnt;        // words still to load (256 when N=0)
    logic [1:0]         r_byte_idx;   // byte position within current word
    logic [23:0]        r_word;       // first three bytes of a load word
    logic [IMEM_AW-1:0] r_waddr;      // address for the next loaded word
    logic               r_ack_wait;   // ack byte sent, waiting for tx_done
    logic [23:0]        r_shift;      // remaining dump bytes of current word
    logic [5:0]         r_word_idx;
    logic               r_imem_we;
    logic [IMEM_AW-1:0] r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic [7:0]         r_tx_data;
    logic [5:0]         r_dbg_sel;

    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign tx_data    = r_tx_data;
    assign dbg_sel    = r_dbg_sel;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        c_CMD_LOAD: w_next = S_LD_CNT;
                        c_CMD_RUN:  w_next = S_RUN;
                        c_CMD_STEP: w_next = S_STEP;
                        c_CMD_DUMP: w_next = S_DUMP_SEL;
                        default:    w_next = S_IDLE;
                    endcase
                end
            end
            S_LD_CNT:     if (rx_valid) w_next = S_LD_DATA;
            S_LD_DATA:    if (rx_valid && r_byte_idx == 2'd3 && r_cnt == 9'd1) w_next = S_LD_ACK;
            S_LD_ACK:     if (r_ack_wait && tx_done) w_next = S_IDLE;
            // halt and an abort byte collapse into the same single exit
            S_RUN:        if (halt || rx_valid) w_next = S_DUMP_SEL;
            S_STEP:       w_next = S_DUMP_SEL;
            S_DUMP_SEL:   w_next = S_DUMP_LATCH;
            S_DUMP_LATCH: w_next = S_DUMP_TX;
            S_DUMP_TX:    w_next = S_DUMP_WAIT;
            S_DUMP_WAIT: begin
                if (tx_done) begin
                    if (r_byte_idx != 2'd3)          w_next = S_DUMP_TX;
                    else if (r_word_idx == c_LAST_IDX) w_next = S_IDLE;
                    else                             w_next = S_DUMP_SEL;
                end
            end
            default:      w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        tx_start = (r_state == S_DUMP_TX) || (r_state == S_LD_ACK && !r_ack_wait);
        cpu_en   = (r_state == S_RUN) || (r_state == S_STEP);
        cpu_rst  = (r_state == S_LD_CNT) || (r_state == S_LD_DATA) || (r_state == S_LD_ACK);
        busy     = (r_state != S_IDLE);
    end

    // Load assembly, dump sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_waddr      <= '0;
            r_ack_wait   <= 1'b0;
            r_shift      <= '0;
            r_word_idx   <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_tx_data    <= '0;
            r_dbg_sel    <= '0;
        end else begin
            r_imem_we <= 1'b0;
            case (r_state)
                S_LD_CNT: begin
                    if (rx_valid) begin
                        r_cnt      <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        r_byte_idx <= 2'd0;
                        r_waddr    <= '0;
                    end
                end
                S_LD_DATA: begin
                    if (rx_valid) begin
                        r_word     <= {r_word[15:0], rx_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_wdata <= {r_word, rx_data};
                            r_imem_addr  <= r_waddr;
                            r_waddr      <= r_waddr + {{(IMEM_AW-1){1'b0}}, 1'b1};
                            r_cnt        <= r_cnt - 9'd1;
                            if (r_cnt == 9'd1) begin
                                r_tx_data  <= c_ACK_BYTE;
                                r_ack_wait <= 1'b0;
                            end
                        end
                    end
                end
                S_LD_ACK: r_ack_wait <= 1'b1;
                S_DUMP_LATCH: begin
                    r_tx_data  <= dbg_data[31:24];
                    r_shift    <= dbg_data[23:0];
                    r_byte_idx <= 2'd0;
                end
                S_DUMP_WAIT: begin
                    if (tx_done) begin
                        if (r_byte_idx != 2'd3) begin
                            r_tx_data  <= r_shift[23:16];
                            r_shift    <= {r_shift[15:0], 8'h00};
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end else if (r_word_idx != c_LAST_IDX) begin
                            r_dbg_sel  <= r_word_idx;
                            r_word_idx <= r_word_idx + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
            // Any fresh dump starts with the PC
            if (w_next == S_DUMP_SEL && r_state != S_DUMP_WAIT) begin
                r_word_idx <= 6'd0;
                r_dbg_sel  <= c_PC_SEL;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_ctrl
// Description : Scoreboard bench for debug_ctrl with a UART transmitter model
//               and a register-file/PC model on the debug read port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_ctrl;

    localparam int IMEM_AW = 8;
    localparam int NREGS   = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               rx_valid = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_done = 1'b0;
    logic               cpu_en;
    logic               cpu_rst;
    logic               halt = 1'b0;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic [5:0]         dbg_sel;
    logic [31:0]        dbg_data;
    logic               busy;

    logic [31:0] regs [NREGS];
    logic [31:0] pc_val = 32'h0;

    logic [7:0]  exp_tx [$];
    logic [39:0] exp_wr [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    bit lat_armed = 1'b0;
    int en_cnt = 0;
    bit outstanding = 1'b0;

    debug_ctrl #(.IMEM_AW(IMEM_AW), .NREGS(NREGS)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .cpu_en     (cpu_en),
        .cpu_rst    (cpu_rst),
        .halt       (halt),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational debug read port model
    always_comb begin
        dbg_data = 32'h0;
        if (dbg_sel == 6'd32)          dbg_data = pc_val;
        else if (int'(dbg_sel) < NREGS) dbg_data = regs[dbg_sel[4:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte or a write
    always @(negedge clk) begin
        if (cpu_en) en_cnt++;
        if (tx_start) begin
            chk("tx_overlap", {63'd0, outstanding}, 64'd0);
            if (exp_tx.size() == 0) begin
                chk("tx_unexpected", {56'd0, tx_data}, 64'hFFFF);
            end else begin
                chk("tx_byte", {56'd0, tx_data}, {56'd0, exp_tx.pop_front()});
            end
            if (lat_armed) begin
                lat_armed = 1'b0;
                checks++;
                if (cyc - t0 > 4) begin
                    errors++;
                    $display("FAIL dump_latency actual=%0d required<=4", cyc - t0);
                end
            end
            outstanding = 1'b1;
        end
        if (imem_we) begin
            chk("wr_cpu_rst", {63'd0, cpu_rst}, 64'd1);
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", {24'd0, imem_addr, imem_wdata}, 64'hFFFF_FFFF_FFFF);
            end else begin
                chk("imem_write", {24'd0, imem_addr, imem_wdata}, {24'd0, exp_wr.pop_front()});
            end
        end
    end

    // UART transmitter model: tx_done three cycles after tx_start
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (3) @(posedge clk);
                #1 tx_done = 1'b1;
                outstanding = 1'b0;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Latency reference is the edge that samples the triggering input
    task automatic arm();
        t0 = cyc + 1;
        lat_armed = 1'b1;
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_tx.push_back(w[31:24]);
        exp_tx.push_back(w[23:16]);
        exp_tx.push_back(w[15:8]);
        exp_tx.push_back(w[7:0]);
    endtask

    task automatic push_dump();
        push_word(pc_val);
        for (int i = 0; i < NREGS; i++) push_word(regs[i]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_outs_zero(input string name);
        chk(name, {5'd0, tx_start, tx_data, cpu_en, cpu_rst, imem_we, imem_addr,
                   imem_wdata, dbg_sel, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk_outs_zero("reset_outputs");
        reset = 1'b0;
        tick();

        // Junk bytes and a stray tx_done are dropped in IDLE
        send(8'h00);
        chk("junk00_busy", {63'd0, busy}, 64'd0);
        send(8'hFF);
        chk("junkFF_busy", {63'd0, busy}, 64'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (3) tick();
        chk("stray_done_busy", {63'd0, busy}, 64'd0);

        // Load two words
        exp_wr.push_back({8'd0, 32'h01020304});
        exp_wr.push_back({8'd1, 32'hAABBCCDD});
        exp_tx.push_back(8'h4B);
        send(8'h4C);
        chk("load_cpu_rst_cnt", {63'd0, cpu_rst}, 64'd1);
        send(8'h02);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("load_cpu_rst_mid", {63'd0, cpu_rst}, 64'd1);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        chk("load_cpu_rst_ack", {63'd0, cpu_rst}, 64'd1);
        wait_idle("load_done", 200);
        chk("load_cpu_rst_end", {63'd0, cpu_rst}, 64'd0);
        chk("load_wr_drained", exp_wr.size(), 0);
        chk("load_tx_drained", exp_tx.size(), 0);

        // Plain dump with a distinct pattern in every register
        pc_val = 32'h12345678;
        for (int i = 0; i < NREGS; i++) regs[i] = {8'(i), 8'(8'hF0 - i), 8'hA5, 8'(3 * i + 1)};
        push_dump();
        en_cnt = 0;
        arm();
        send(8'h44);
        wait_idle("dump_done", 3000);
        chk("dump_drained", exp_tx.size(), 0);
        chk("dump_no_cpu_en", en_cnt, 0);

        // Step: exactly one enabled cycle then 132 bytes
        pc_val = 32'h00400004;
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h0;
        push_dump();
        en_cnt = 0;
        arm();
        send(8'h53);
        wait_idle("step_done", 3000);
        chk("step_en_cycles", en_cnt, 1);
        chk("step_drained", exp_tx.size(), 0);

        // Run until halt at cycle 20
        pc_val = 32'hDEADBEEF;
        regs[5] = 32'h0BADF00D;
        push_dump();
        en_cnt = 0;
        send(8'h52);
        chk("run_en_first", {63'd0, cpu_en}, 64'd1);
        repeat (19) tick();
        halt = 1'b1;
        arm();
        tick();
        halt = 1'b0;
        chk("run_en_after_halt", {63'd0, cpu_en}, 64'd0);
        chk("run_en_cycles", en_cnt, 20);
        wait_idle("run_done", 3000);
        chk("run_drained", exp_tx.size(), 0);

        // Run aborted by 0x99 coinciding with halt: a single dump
        push_dump();
        send(8'h52);
        repeat (5) tick();
        halt = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h99;
        arm();
        tick();
        halt = 1'b0;
        rx_valid = 1'b0;
        wait_idle("abort_done", 3000);
        chk("abort_drained", exp_tx.size(), 0);
        repeat (30) tick();
        chk("abort_stays_idle", {63'd0, busy}, 64'd0);

        // Reset after the third byte of a load word
        send(8'h4C);
        send(8'h01);
        send(8'h11); send(8'h22); send(8'h33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_outs_zero("midload_reset_outputs");
        repeat (5) tick();
        chk("midload_no_write", exp_wr.size(), 0);
        push_dump();
        arm();
        send(8'h44);
        wait_idle("post_reset_dump", 3000);
        chk("post_reset_drained", exp_tx.size(), 0);

        repeat (10) tick();
        chk("final_tx_queue", exp_tx.size(), 0);
        chk("final_wr_queue", exp_wr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 The block SHALL have parameter IMEM_AW, default 8, meaning the instruction-memory word-address width.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the number of register-file entries dumped.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port rx_valid, input, 1, a one-cycle strobe for a received UART byte.
REQ-006 The block SHALL have port rx_data, input, 8, the received byte, valid with rx_valid.
REQ-007 The block SHALL have port tx_start, output, 1, a one-cycle strobe that sends tx_data.
REQ-008 The block SHALL have port tx_data, output, 8, the byte to send, held stable from tx_start until tx_done.
REQ-009 The block SHALL have port tx_done, input, 1, a one-cycle strobe from the UART transmitter when a byte completes.
REQ-010 The block SHALL have port cpu_en, output, 1, the datapath clock-enable.
REQ-011 The block SHALL have port cpu_rst, output, 1, the datapath reset request.
REQ-012 The block SHALL have port halt, input, 1, asserted by the datapath when it retires a halt instruction.
REQ-013 The block SHALL have ports imem_we (output, 1), imem_addr (output, IMEM_AW) and imem_wdata (output, 32), the instruction-memory write port.
REQ-014 The block SHALL have ports dbg_sel (output, 6) and dbg_data (input, 32), the debug read port; dbg_sel 0..NREGS-1 selects a register, 32 selects PC, and the read is combinational.
REQ-015 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LD_CNT, LD_DATA, LD_ACK, RUN, STEP, DUMP_SEL, DUMP_LATCH, DUMP_TX and DUMP_WAIT.
REQ-017 In IDLE, command bytes SHALL be decoded: 0x4C load, 0x52 run, 0x53 step, 0x44 dump; any other byte is dropped with no state change.
REQ-018 Load: on 0x4C, the FSM SHALL go to LD_CNT and assert cpu_rst=1 until LD_ACK completes.
REQ-019 In LD_CNT, the next byte N SHALL be the word count, with N=0 meaning 256.
REQ-020 In LD_DATA, bytes SHALL be assembled big-endian (first byte in [31:24]) and, on each 4th byte, imem_we SHALL pulse for one cycle.
REQ-021 On that imem_we pulse, imem_wdata SHALL equal the assembled word; imem_addr SHALL be 0 for the first word and increment by 1 per word, wrapping modulo 2^IMEM_AW.
REQ-022 After the Nth word is written, the FSM SHALL go to LD_ACK, send 0x4B once, wait for tx_done, then return to IDLE with cpu_rst=0.
REQ-023 Run: on 0x52, cpu_en SHALL be 1 continuously from the next cycle while in RUN.
REQ-024 RUN SHALL exit when halt=1 or when any rx_valid arrives (abort); cpu_en SHALL drop to 0 the cycle after the exit condition, and a dump follows.
REQ-025 If halt and rx_valid coincide in RUN, the result SHALL be a single exit and dump, with the rx byte discarded.
REQ-026 Step: on 0x53, cpu_en SHALL be 1 for exactly one cycle, and a dump follows.
REQ-027 Dump (0x44, or after RUN/STEP): the block SHALL send 4*(NREGS+1) bytes, PC first, then registers 0..NREGS-1, each word MSB first.
REQ-028 Dump sequencing: DUMP_SEL drives dbg_sel; DUMP_LATCH captures dbg_data; DUMP_TX pulses tx_start; DUMP_WAIT waits for tx_done; then the next byte follows, or the next word, or IDLE after the last byte.
REQ-029 The first dump tx_start SHALL occur no later than 4 cycles after the triggering event.
REQ-030 Only one tx_start SHALL be outstanding at a time, and the next tx_start SHALL come no earlier than the cycle after tx_done.
REQ-031 rx_valid received in any state other than IDLE, LD_CNT, LD_DATA or RUN SHALL be ignored.
REQ-032 A tx_done strobe arriving when none is awaited SHALL be ignored.
REQ-033 The datapath SHALL be frozen (cpu_en=0) in every state except RUN and the STEP cycle.

Reset
REQ-034 With reset=1 at a clk edge, the FSM SHALL go to IDLE and all outputs SHALL be 0 (tx_data=0x00, imem_addr=0, dbg_sel=0, busy=0) on the next cycle.
REQ-035 Reset SHALL take priority over every other input, including a reset arriving mid-load or mid-dump; no further imem_we or tx_start occurs and partial words are discarded.

Verification
REQ-036 Load test: 0x4C, 0x02, 01 02 03 04, AA BB CC DD -> imem_we pulses at addr 0 with 0x01020304 and at addr 1 with 0xAABBCCDD, then tx 0x4B, cpu_rst high throughout.
REQ-037 Step test: 0x53 with dbg_data=0x00400004 at sel 32 and zeros elsewhere -> one cpu_en cycle, then 132 bytes: 00 40 00 04 then 128 x 0x00.
REQ-038 Run/halt test: 0x52, halt raised at cycle 20 -> cpu_en high cycles 1..20, low from 21, dump follows.
REQ-039 Run abort test: 0x52, rx 0x99 at the same cycle as halt -> exactly one dump of 132 bytes, 0x99 not decoded.
REQ-040 Reset test: reset asserted after the 3rd byte of a load word -> no imem_we, outputs 0, and a following 0x44 yields a normal dump.
REQ-041 Junk test: 0x00, 0xFF in IDLE -> no tx_start, busy stays 0.
